// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX hazard sources in, register
// enables/flushes and MD/stall status out.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_md_use;
  logic             id_jump;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             ex_branch_taken;
  logic             ex_md_start;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             md_busy;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md_use, id_jump,
           ex_mem_read, ex_rt, ex_branch_taken, ex_md_start, mem_busy,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, md_busy, ctrl_state, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_use, id_jump,
           ex_mem_read, ex_rt, ex_branch_taken, ex_md_start, mem_busy,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, md_busy, ctrl_state, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritised freeze/redirect/jump/stall decode,
// multiply/divide occupancy counter and saturating stall counter.
module hazard_ctrl #(
    parameter int unsigned MD_CYCLES = 32,
    parameter int unsigned CNT_W     = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave bus
);
    // JUMP shares code 0 with RUN in the registered class
    typedef enum logic [1:0] {
        CS_RUN      = 2'd0,
        CS_STALL    = 2'd1,
        CS_FREEZE   = 2'd2,
        CS_REDIRECT = 2'd3
    } cls_e;

    localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES - 1);

    logic [7:0]       r_md_cnt;
    cls_e             r_state;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_md_busy;
    logic w_load_use;
    logic w_md_haz;
    cls_e w_cls;
    logic w_pc_write;
    logic w_if_id_write;
    logic w_id_ex_write;
    logic w_ex_mem_write;
    logic w_if_id_flush;
    logic w_id_ex_flush;

    assign w_md_busy = (r_md_cnt != '0);

    always_comb begin
        w_load_use = bus.ex_mem_read && (bus.ex_rt != '0) &&
                     ((bus.id_use_rs && (bus.id_rs == bus.ex_rt)) ||
                      (bus.id_use_rt && (bus.id_rt == bus.ex_rt)));
        w_md_haz   = w_md_busy && bus.id_md_use;

        w_cls          = CS_RUN;
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_write  = 1'b1;
        w_ex_mem_write = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;

        if (!rst_n) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
        end else if (bus.mem_busy) begin
            w_cls          = CS_FREEZE;
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_write  = 1'b0;
            w_ex_mem_write = 1'b0;
        end else if (bus.ex_branch_taken) begin
            w_cls         = CS_REDIRECT;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (bus.id_jump) begin
            w_if_id_flush = 1'b1;
        end else if (w_load_use || w_md_haz) begin
            w_cls         = CS_STALL;
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_cnt    <= '0;
            r_state     <= CS_RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_cls;
            if (!w_pc_write && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            // memory stall freezes the MD count and masks new starts
            if (!bus.mem_busy) begin
                if (bus.ex_md_start)
                    r_md_cnt <= MD_LOAD;
                else if (r_md_cnt != '0)
                    r_md_cnt <= r_md_cnt - 8'd1;
            end
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.id_ex_write  = w_id_ex_write;
    assign bus.ex_mem_write = w_ex_mem_write;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.id_ex_flush  = w_id_ex_flush;
    assign bus.md_busy      = w_md_busy;
    assign bus.ctrl_state   = r_state;
    assign bus.stall_cnt    = r_stall_cnt;
endmodule
